// File: rtl/motor_meter_pkg.sv
// Shared definitions for the motor metering blocks: meter state encoding and
// the widths of the speed/position words and of the hall edge counter.
package motor_meter_pkg;

  localparam int SPEED_W = 16;
  localparam int COUNT_W = 8;

  // PRIME waits for the first window edge to capture a baseline hall count;
  // RUN produces a speed sample on every window edge after that.
  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } meter_state_t;

  // Sign-extend an 8-bit hall count delta to the speed/position width.
  function automatic logic [SPEED_W-1:0] sext_delta(input logic [COUNT_W-1:0] d);
    return {{(SPEED_W-COUNT_W){d[COUNT_W-1]}}, d};
  endfunction

endpackage

// File: rtl/hall_speed_meter_sample_timer.sv
// Sample window timer: counts 0..SAMPLE_PERIOD-1 and wraps. tick is high for
// the single terminal cycle of each window; the rising edge that ends that
// cycle is the sample edge.
module sample_timer #(
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running window counter; reset starts a fresh window at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/hall_speed_meter.sv
// Hall speed meter: once per sample window, turns the free-running hall edge
// count into a signed per-window speed and an accumulated position, with a
// host snapshot handshake and a sticky fault latch.
// Optional feature: define HALL_OVERSPEED_EN to build the overspeed latch
// (|delta| > OVERSPEED_LIMIT); without it overspeed is tied low.
module hall_speed_meter
  import motor_meter_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50000
`ifdef HALL_OVERSPEED_EN
  , parameter int OVERSPEED_LIMIT = 100
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COUNT_W-1:0] hall_count,
  input  logic               fault,
  input  logic               fault_clear,
  input  logic               snap_req,
  output logic               snap_ack,
  output logic [SPEED_W-1:0] snap_speed,
  output logic [SPEED_W-1:0] snap_position,
  output logic               sample_valid,
  output logic               fault_sticky,
  output logic               overspeed
);

  meter_state_t       state;
  logic [COUNT_W-1:0] prev_count;
  logic [SPEED_W-1:0] speed;
  logic [SPEED_W-1:0] position;
  logic               tick;
  logic [COUNT_W-1:0] delta;

  sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Modulo-256 difference; read as signed it covers -128..+127 per window.
  assign delta = hall_count - prev_count;

  // Window sampling: PRIME only captures the baseline, RUN updates speed/position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PRIME;
      prev_count   <= '0;
      speed        <= '0;
      position     <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (tick) begin
        prev_count <= hall_count;
        if (state == PRIME) begin
          state <= RUN;
        end else begin
          speed        <= sext_delta(delta);
          position     <= position + sext_delta(delta);
          sample_valid <= 1'b1;
        end
      end
    end
  end

  // Snapshot handshake: captures the values held before this edge, so a
  // request coinciding with a sample edge sees the pre-update speed/position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_ack      <= 1'b0;
      snap_speed    <= '0;
      snap_position <= '0;
    end else if (snap_req && !snap_ack) begin
      snap_ack      <= 1'b1;
      snap_speed    <= speed;
      snap_position <= position;
    end else begin
      snap_ack <= 1'b0;
    end
  end

  // Sticky fault latch; a new fault wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault_sticky <= 1'b0;
    else if (fault)
      fault_sticky <= 1'b1;
    else if (fault_clear)
      fault_sticky <= 1'b0;
  end

`ifdef HALL_OVERSPEED_EN
  logic [COUNT_W-1:0] delta_mag;

  // Magnitude of the signed delta; -128 maps to 8'h80 = 128 unsigned.
  assign delta_mag = delta[COUNT_W-1] ? COUNT_W'(~delta + 1'b1) : delta;

  // Overspeed latch, set on a RUN sample edge, cleared by fault_clear (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overspeed <= 1'b0;
    else if (tick && (state == RUN) && (32'(delta_mag) > OVERSPEED_LIMIT))
      overspeed <= 1'b1;
    else if (fault_clear)
      overspeed <= 1'b0;
  end
`else
  assign overspeed = 1'b0;
`endif

endmodule

// File: tb/tb_hall_speed_meter.sv
// Directed bench for hall_speed_meter with SAMPLE_PERIOD = 4. Inputs are
// driven and outputs sampled on the falling clock edge; cyc counts rising
// edges since the last reset release, so sample edges fall on cyc % 4 == 0.
// Overspeed expectations follow HALL_OVERSPEED_EN.
module tb_hall_speed_meter;
  import motor_meter_pkg::*;

  localparam int PERIOD = 4;
`ifdef HALL_OVERSPEED_EN
  localparam logic OVS_EXP = 1'b1;
`else
  localparam logic OVS_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  hall_count;
  logic        fault;
  logic        fault_clear;
  logic        snap_req;
  logic        snap_ack;
  logic [15:0] snap_speed;
  logic [15:0] snap_position;
  logic        sample_valid;
  logic        fault_sticky;
  logic        overspeed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  hall_speed_meter #(
    .SAMPLE_PERIOD(PERIOD)
`ifdef HALL_OVERSPEED_EN
    , .OVERSPEED_LIMIT(100)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hall_count    (hall_count),
    .fault         (fault),
    .fault_clear   (fault_clear),
    .snap_req      (snap_req),
    .snap_ack      (snap_ack),
    .snap_speed    (snap_speed),
    .snap_position (snap_position),
    .sample_valid  (sample_valid),
    .fault_sticky  (fault_sticky),
    .overspeed     (overspeed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Advance to the falling edge right after the next sample edge.
  task automatic next_sample();
    do step(1); while (cyc % PERIOD != 0);
  endtask

  // Issue a one-cycle snapshot request and check the captured values.
  task automatic snap_check(input string tag, input logic [15:0] exp_spd, input logic [15:0] exp_pos);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    check({tag, "_ack"}, 32'(snap_ack), 32'd1);
    check({tag, "_spd"}, 32'(snap_speed), 32'(exp_spd));
    check({tag, "_pos"}, 32'(snap_position), 32'(exp_pos));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  32'(snap_ack), 32'd0);
    check({tag, "_spd"},  32'(snap_speed), 32'd0);
    check({tag, "_pos"},  32'(snap_position), 32'd0);
    check({tag, "_sv"},   32'(sample_valid), 32'd0);
    check({tag, "_flt"},  32'(fault_sticky), 32'd0);
    check({tag, "_ovs"},  32'(overspeed), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    hall_count  = 8'd10;
    fault       = 1'b0;
    fault_clear = 1'b0;
    snap_req    = 1'b0;

    // Reset state, held across several clock edges.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 32'(dut.state), 32'(PRIME));
    rst_n = 1'b1;
    cyc   = 0;

    // Constant hall count: PRIME edge gives no pulse, RUN edges give zero speed.
    next_sample();
    check("prime_no_sv", 32'(sample_valid), 32'd0);
    next_sample();
    check("run_sv", 32'(sample_valid), 32'd1);
    step(1);
    check("sv_one_cycle", 32'(sample_valid), 32'd0);

    // Held request: one ack only, second cycle ignored.
    snap_req = 1'b1;
    step(1);
    check("const_ack", 32'(snap_ack), 32'd1);
    check("const_spd", 32'(snap_speed), 32'd0);
    check("const_pos", 32'(snap_position), 32'd0);
    step(1);
    snap_req = 1'b0;
    check("held_req_no_ack", 32'(snap_ack), 32'd0);

    // Edge 12 still sees delta 0; then 10 -> 250 gives -16.
    next_sample();
    hall_count = 8'd250;
    next_sample();
    snap_check("neg16", 16'hFFF0, 16'hFFF0);

    // 250 -> 5 wraps the hall counter: +11.
    hall_count = 8'd5;
    next_sample();
    snap_check("wrap_p11", 16'h000B, 16'hFFFB);

    // 5 -> 250: -11.
    hall_count = 8'd250;
    next_sample();
    snap_check("wrap_m11", 16'hFFF5, 16'hFFF0);

    // Speed 3 then 7, snapshot coinciding with the edge that loads 7.
    hall_count = 8'd253;
    next_sample();
    hall_count = 8'd4;
    step(PERIOD - 1);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    check("coinc_sv", 32'(sample_valid), 32'd1);
    check("coinc_ack", 32'(snap_ack), 32'd1);
    check("coinc_spd", 32'(snap_speed), 32'd3);
    check("coinc_pos", 32'(snap_position), 32'hFFF3);
    step(1);
    check("coinc_ack_drop", 32'(snap_ack), 32'd0);
    check("snap_stable", 32'(snap_speed), 32'd3);
    snap_check("after_coinc", 16'd7, 16'hFFFA);

    // Fault latch: set wins, clear alone clears, fault alone holds.
    fault = 1'b1; fault_clear = 1'b1;
    step(1);
    check("flt_set_wins", 32'(fault_sticky), 32'd1);
    fault = 1'b0;
    step(1);
    check("flt_cleared", 32'(fault_sticky), 32'd0);
    fault_clear = 1'b0; fault = 1'b1;
    step(1);
    fault = 1'b0;
    step(1);
    check("flt_holds", 32'(fault_sticky), 32'd1);
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    check("flt_clear2", 32'(fault_sticky), 32'd0);

    // Overspeed threshold: +100 stays low, +101 latches (feature builds only).
    next_sample();
    hall_count = 8'd104;
    next_sample();
    check("ovs_at_limit", 32'(overspeed), 32'd0);
    hall_count = 8'd205;
    next_sample();
    check("ovs_over_limit", 32'(overspeed), 32'(OVS_EXP));
    step(1);
    check("ovs_latched", 32'(overspeed), 32'(OVS_EXP));
    fault_clear = 1'b1;
    step(1);
    fault_clear = 1'b0;
    check("ovs_cleared", 32'(overspeed), 32'd0);

    // Leave a nonzero fault_sticky and snapshot, then reset mid-window.
    fault = 1'b1;
    step(1);
    fault = 1'b0;
    snap_check("pre_rst", 16'd101, 16'hFFFA + 16'd201);
    step(1);
    check("pre_rst_flt", 32'(fault_sticky), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("rst_state", 32'(dut.state), 32'(PRIME));
    step(2);
    check_all_zero("rst_held");

    // Fresh window after release: PRIME edge at cyc 4, first sample at cyc 8.
    hall_count = 8'd50;
    rst_n = 1'b1;
    cyc   = 0;
    step(PERIOD);
    check("fresh_prime", 32'(sample_valid), 32'd0);
    hall_count = 8'd53;
    step(PERIOD - 1);
    check("fresh_no_early_sv", 32'(sample_valid), 32'd0);
    step(1);
    check("fresh_sv", 32'(sample_valid), 32'd1);
    snap_check("fresh", 16'd3, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hall_speed_meter.md
HALL_SPEED_METER -- requirements
Module: hall_speed_meter

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 50000; clk cycles per speed sample window (legal range 2..2^20).
REQ-002 SHALL have parameter OVERSPEED_LIMIT, default 100; magnitude threshold on per-window delta (present only with HALL_OVERSPEED_EN).
REQ-003 SHALL have port clk, input, 1; sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port hall_count, input, 8; free-running hall edge counter from the motor block, synchronous to clk.
REQ-006 SHALL have port fault, input, 1; illegal hall-state indication from the motor block.
REQ-007 SHALL have port fault_clear, input, 1; one-cycle pulse that clears fault_sticky.
REQ-008 SHALL have port snap_req, input, 1; host snapshot request pulse.
REQ-009 SHALL have port snap_ack, output, 1; one-cycle pulse, snapshot registers valid.
REQ-010 SHALL have port snap_speed, output, 16; signed speed snapshot.
REQ-011 SHALL have port snap_position, output, 16; signed position snapshot.
REQ-012 SHALL have port sample_valid, output, 1; one-cycle pulse per completed window.
REQ-013 SHALL have port fault_sticky, output, 1; latched fault.
REQ-014 SHALL have port overspeed, output, 1; latched overspeed flag (constant 0 without HALL_OVERSPEED_EN).

Function
REQ-015 SHALL run a period counter 0..SAMPLE_PERIOD-1 that wraps to 0; the terminal cycle (count == SAMPLE_PERIOD-1) is the sample edge.
REQ-016 SHALL implement states PRIME and RUN; PRIME is entered on reset; on the first sample edge it loads prev_count <= hall_count, asserts no sample_valid and moves to RUN; RUN never exits except by reset.
REQ-017 SHALL, on each sample edge in RUN, compute delta = hall_count - prev_count modulo 256, interpreted as signed 8-bit (-128..+127), then load prev_count <= hall_count.
REQ-018 SHALL, on the same edge, load speed <= sign-extended delta (16 bit) and position <= position + sign-extended delta, wrapping modulo 2^16 with no saturation.
REQ-019 SHALL assert sample_valid on the cycle after each RUN sample edge, for exactly one cycle.
REQ-020 SHALL, on snap_req, load snap_speed/snap_position from the internal speed/position values held before that edge, and assert snap_ack on the following cycle for one cycle.
REQ-021 SHALL, when snap_req coincides with a sample edge, snapshot the pre-update values; the update still occurs on that edge.
REQ-022 SHALL ignore snap_req while snap_ack is high, with no second ack.
REQ-023 SHALL set fault_sticky when fault = 1 and clear it on fault_clear; set wins when both occur in the same cycle.
REQ-024 SHALL keep snap_* outputs stable except on the edge that loads them.

Reset
REQ-025 SHALL asynchronously force state = PRIME, period counter = 0, prev_count = 0, speed = 0, position = 0, snap_speed = 0, snap_position = 0, snap_ack = 0, sample_valid = 0, fault_sticky = 0 and overspeed = 0 while rst_n = 0.
REQ-026 SHALL, after rst_n deasserts mid-window, begin a fresh window at count 0 and discard the partial window.

Configuration
REQ-027 SHALL compile overspeed detection only when macro HALL_OVERSPEED_EN is defined; overspeed then latches high on any RUN sample edge with |delta| > OVERSPEED_LIMIT and clears only on fault_clear (set wins); without the macro, overspeed is tied to 0 and no comparator logic exists.

Structure
REQ-028 SHALL place the state enum (PRIME, RUN), SPEED_W = 16 and COUNT_W = 8 in shared package motor_meter_pkg.
REQ-029 SHALL implement the window counter as sub-module sample_timer (parameter SAMPLE_PERIOD; output tick, a one-cycle pulse on the terminal cycle).

Verification
REQ-030 SHALL cover: SAMPLE_PERIOD = 4, hall_count held at 10 -> first tick gives no sample_valid; subsequent ticks give speed = 0 and position = 0.
REQ-031 SHALL cover: hall_count 250 -> 5 across one window -> speed = +11 and position incremented by 11 (wrap-around).
REQ-032 SHALL cover: hall_count 5 -> 250 across one window -> speed = -11 (16'hFFF5).
REQ-033 SHALL cover: snap_req on the same cycle as the sample edge (old speed 3, new 7) -> snap_speed = 3, snap_ack one cycle later, internal speed = 7.
REQ-034 SHALL cover: fault and fault_clear asserted in the same cycle -> fault_sticky = 1; fault_clear alone on the next cycle -> fault_sticky = 0.
REQ-035 SHALL cover: with HALL_OVERSPEED_EN and OVERSPEED_LIMIT = 100, delta = +101 -> overspeed = 1; delta = +100 -> overspeed stays 0; and rst_n pulsed low mid-window -> all outputs 0 and state = PRIME.
